// File: rtl/rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_sync_ctrl
// Purpose  : Receive-side lane synchronization controller. Finds byte
//            alignment on the comma symbol, requests a bit slip when no
//            comma shows up, declares the lane active after a run of
//            commas, qualifies payload bytes and detects loss of sync.
// Revision : 1.0 - initial release
// ============================================================================
module rx_sync_ctrl #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         SYNC_COUNT  = 4,
  parameter int         SLIP_WINDOW = 8,
  parameter int         SLIP_SETTLE = 2,
  parameter int         LOSS_WINDOW = 16
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic       lane_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       slip,
  output logic [3:0] bc_count
);

  localparam int WIN_W    = $clog2(SLIP_WINDOW + 1);
  localparam int SETTLE_W = $clog2(SLIP_SETTLE + 1);
  localparam int GAP_W    = $clog2(LOSS_WINDOW + 1);

  // Terminal values: a counter sitting at *_LAST means the byte being
  // sampled now is the one that completes its window.
  localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(SLIP_WINDOW - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(LOSS_WINDOW - 1);
  localparam logic [3:0]          SYNC_LAST   = 4'(SYNC_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEARCH    = 3'd1,
    SLIP_WAIT = 3'd2,
    SYNC      = 3'd3,
    ACTIVE    = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [WIN_W-1:0]    win_cnt, win_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic [7:0]          data_nxt;
  logic                valid_nxt, active_nxt, slip_nxt;
  logic [3:0]          bc_nxt;
  logic                is_comma;

  assign is_comma = (data_in == COMMA);

  // State register.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus next values of every registered output and counter.
  always_comb begin
    state_nxt  = state;
    data_nxt   = data_in;
    valid_nxt  = 1'b0;
    active_nxt = active;
    slip_nxt   = 1'b0;
    bc_nxt     = bc_count;
    win_nxt    = win_cnt;
    settle_nxt = settle_cnt;
    gap_nxt    = gap_cnt;

    if (!lane_en) begin
      // Disabling the lane overrides everything and clears all state.
      state_nxt  = IDLE;
      data_nxt   = 8'h00;
      active_nxt = 1'b0;
      bc_nxt     = 4'd0;
      win_nxt    = '0;
      settle_nxt = '0;
      gap_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SEARCH;
        end

        SEARCH: begin
          // A comma on the window's last byte takes precedence over a slip.
          if (is_comma) begin
            bc_nxt  = 4'd1;
            win_nxt = '0;
            if (SYNC_COUNT == 1) begin
              state_nxt  = ACTIVE;
              active_nxt = 1'b1;
            end else begin
              state_nxt = SYNC;
            end
          end else if (win_cnt == WIN_LAST) begin
            slip_nxt  = 1'b1;
            win_nxt   = '0;
            state_nxt = SLIP_WAIT;
          end else begin
            win_nxt = win_cnt + WIN_W'(1);
          end
        end

        SLIP_WAIT: begin
          // Bytes arriving while the deserializer realigns are meaningless.
          if (settle_cnt == SETTLE_LAST) begin
            settle_nxt = '0;
            state_nxt  = SEARCH;
          end else begin
            settle_nxt = settle_cnt + SETTLE_W'(1);
          end
        end

        SYNC: begin
          if (is_comma) begin
            bc_nxt = bc_count + 4'd1;
            if (bc_count == SYNC_LAST) begin
              state_nxt  = ACTIVE;
              active_nxt = 1'b1;
            end
          end else begin
            // Broken run: restart the search without slipping.
            bc_nxt    = 4'd0;
            state_nxt = SEARCH;
          end
        end

        ACTIVE: begin
          valid_nxt = !is_comma;
          if (is_comma) begin
            gap_nxt = '0;
          end else if (gap_cnt == GAP_LAST) begin
            // Loss of sync: the byte completing the gap is dropped.
            state_nxt  = SEARCH;
            active_nxt = 1'b0;
            valid_nxt  = 1'b0;
            bc_nxt     = 4'd0;
            gap_nxt    = '0;
          end else begin
            gap_nxt = gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state_nxt  = IDLE;
          active_nxt = 1'b0;
          bc_nxt     = 4'd0;
          win_nxt    = '0;
          settle_nxt = '0;
          gap_nxt    = '0;
        end
      endcase
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      active     <= 1'b0;
      slip       <= 1'b0;
      bc_count   <= 4'd0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      gap_cnt    <= '0;
    end else begin
      data_out   <= data_nxt;
      valid_out  <= valid_nxt;
      active     <= active_nxt;
      slip       <= slip_nxt;
      bc_count   <= bc_nxt;
      win_cnt    <= win_nxt;
      settle_cnt <= settle_nxt;
      gap_cnt    <= gap_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_sync_ctrl
// Purpose  : Directed self-checking bench for rx_sync_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_sync_ctrl;

  localparam logic [7:0] BC = 8'hBC;

  logic       clk_f = 1'b0;
  logic       reset = 1'b0;
  logic       lane_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       slip;
  logic [3:0] bc_count;

  int n_checks = 0;
  int n_pass   = 0;

  rx_sync_ctrl dut (
    .clk_f     (clk_f),
    .reset     (reset),
    .lane_en   (lane_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .slip      (slip),
    .bc_count  (bc_count)
  );

  // 100 MHz byte clock.
  always #5 clk_f = ~clk_f;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Present one byte, let one edge sample it, settle 1 ns past the edge.
  task automatic step(input logic [7:0] b);
    data_in = b;
    @(posedge clk_f);
    #1;
  endtask

  // Feed four commas from SEARCH; lane must go active on the fourth.
  task automatic acquire(input string tag);
    for (int i = 1; i <= 4; i++) begin
      step(BC);
      check({tag, "_bc"}, int'(bc_count), i);
      check({tag, "_act"}, int'(active), (i == 4) ? 1 : 0);
      check({tag, "_slip"}, int'(slip), 0);
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_dout"}, int'(data_out), 0);
    check({tag, "_valid"}, int'(valid_out), 0);
    check({tag, "_act"}, int'(active), 0);
    check({tag, "_slip"}, int'(slip), 0);
    check({tag, "_bc"}, int'(bc_count), 0);
  endtask

  initial begin
    // ---------------- reset ----------------
    #2;
    all_zero("rst");
    repeat (2) @(posedge clk_f);
    #1;
    reset   = 1'b1;
    lane_en = 1'b1;
    step(8'h00);                        // IDLE -> SEARCH
    check("idle_dout", int'(data_out), 8'h00);

    // ---------------- acquire ----------------
    acquire("acq");
    step(8'h55);
    check("acq_dout", int'(data_out), 8'h55);
    check("acq_valid", int'(valid_out), 1);
    step(BC);
    check("acq_bc_valid", int'(valid_out), 0);
    check("acq_bc_dout", int'(data_out), 8'hBC);
    check("acq_bc_hold", int'(bc_count), 4);

    // ---------------- broken sync ----------------
    lane_en = 1'b0;
    step(8'h00);
    check("dis_act", int'(active), 0);
    lane_en = 1'b1;
    step(8'h00);                        // IDLE -> SEARCH
    step(BC);
    check("brk_bc1", int'(bc_count), 1);
    step(BC);
    check("brk_bc2", int'(bc_count), 2);
    step(8'h12);
    check("brk_bc0", int'(bc_count), 0);
    check("brk_slip", int'(slip), 0);
    check("brk_act", int'(active), 0);
    acquire("brk");

    // ---------------- loss ----------------
    for (int i = 0; i < 15; i++) begin
      step(8'hA5);
      check("gap15_valid", int'(valid_out), 1);
      check("gap15_act", int'(active), 1);
    end
    step(BC);
    check("gap15_bc_act", int'(active), 1);
    check("gap15_bc_valid", int'(valid_out), 0);
    for (int i = 1; i <= 16; i++) begin
      step(8'hA5);
      check("loss_valid", int'(valid_out), (i < 16) ? 1 : 0);
      check("loss_act", int'(active), (i < 16) ? 1 : 0);
    end
    check("loss_bc", int'(bc_count), 0);
    check("loss_dout", int'(data_out), 8'hA5);

    // ---------------- slip ----------------
    for (int i = 1; i <= 8; i++) begin
      step(8'h00);
      check("slip_pulse", int'(slip), (i == 8) ? 1 : 0);
    end
    step(BC);
    check("slip_one_cycle", int'(slip), 0);
    check("settle_bc0", int'(bc_count), 0);
    step(BC);
    check("settle_bc1", int'(bc_count), 0);
    acquire("slip");

    // ---------------- comma on window-expiry byte ----------------
    lane_en = 1'b0;
    step(8'h00);
    lane_en = 1'b1;
    step(8'h00);                        // IDLE -> SEARCH
    for (int i = 0; i < 7; i++) begin
      step(8'h00);
      check("win7_slip", int'(slip), 0);
    end
    step(BC);
    check("win8bc_slip", int'(slip), 0);
    check("win8bc_bc", int'(bc_count), 1);
    step(BC);
    check("win8bc_bc2", int'(bc_count), 2);

    // ---------------- lane_en=0 during SYNC ----------------
    lane_en = 1'b0;
    step(8'h3C);
    check("en0_bc", int'(bc_count), 0);
    check("en0_dout", int'(data_out), 0);
    check("en0_act", int'(active), 0);
    lane_en = 1'b1;
    step(8'h00);                        // IDLE -> SEARCH
    acquire("en1");
    step(8'h77);
    check("pre_rst_valid", int'(valid_out), 1);

    // ---------------- asynchronous reset mid-operation ----------------
    #1;
    reset = 1'b0;
    #1;
    all_zero("arst");
    @(posedge clk_f);
    #1;
    reset = 1'b1;
    step(8'h00);                        // IDLE -> SEARCH
    check("post_rst_act", int'(active), 0);
    acquire("reacq");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000 ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
